// File: rtl/i2c_bus_decoder.sv
// I2C bus front end: sync, deglitch, START/STOP/edge decode,
// and first-byte address capture for the slave controller.
module i2c_bus_decoder #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 2,
  parameter bit GC_EN       = 1'b1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       scl,
  input  logic       sda_in,
  input  logic [6:0] slave_addr,
  input  logic [6:0] addr_mask,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic       start_found,
  output logic       rstart_found,
  output logic       stop_found,
  output logic       bus_busy,
  output logic       addr_valid,
  output logic       address_match,
  output logic       rw_mode,
  output logic       general_call
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {IDLE, ADDR, HOLD} state_e;

  // index 0 = SCL, index 1 = SDA
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic [1:0]             sync_out;
  logic [1:0]             filt_q, filt_d, prev_q;
  logic [1:0][CW-1:0]     cnt_q, cnt_d;

  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, shift_nx;
  logic       match_q, match_d;
  logic       rw_q, rw_d;
  logic       gc_q, gc_d;
  logic       av_q, av_d;
  logic       busy_q, busy_d;

  logic scl_cur, scl_prev, sda_cur, sda_prev;
  logic start_w, stop_w, rise_w;

  assign sync_out = {sda_sync_q[SYNC_STAGES-1], scl_sync_q[SYNC_STAGES-1]};

  // Synchroniser chains; idle bus level is high
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    end
  end

  // Level filter: accept a change only after FILTER_LEN differing samples
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_out[i] != filt_q[i]) begin
        if (cnt_q[i] == CW'(FILTER_LEN - 1)) filt_d[i] = sync_out[i];
        else cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Filtered level and its one-cycle-delayed copy
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      filt_q <= '1;
      prev_q <= '1;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      prev_q <= filt_q;
      cnt_q  <= cnt_d;
    end
  end

  assign scl_cur  = filt_q[0];
  assign scl_prev = prev_q[0];
  assign sda_cur  = filt_q[1];
  assign sda_prev = prev_q[1];

  assign start_w = scl_prev & scl_cur & sda_prev & ~sda_cur;
  assign stop_w  = scl_prev & scl_cur & ~sda_prev & sda_cur;
  assign rise_w  = ~scl_prev & scl_cur;

  assign shift_nx = {shift_q[6:0], sda_cur};

  // Next-state: bus conditions override the address shifter
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    match_d   = match_q;
    rw_d      = rw_q;
    gc_d      = gc_q;
    av_d      = 1'b0;
    busy_d    = busy_q;
    if (start_w || stop_w) begin
      state_d   = start_w ? ADDR : IDLE;
      busy_d    = start_w;
      bit_cnt_d = '0;
      shift_d   = '0;
      match_d   = 1'b0;
      rw_d      = 1'b0;
      gc_d      = 1'b0;
    end else if (state_q == ADDR && rise_w) begin
      shift_d   = shift_nx;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        state_d = HOLD;
        match_d = ((shift_nx[7:1] ^ slave_addr) & addr_mask) == 7'd0;
        rw_d    = shift_nx[0];
        gc_d    = GC_EN & (shift_nx == 8'h00);
        av_d    = 1'b1;
      end
    end
  end

  // Address FSM and held decode results
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      match_q   <= 1'b0;
      rw_q      <= 1'b0;
      gc_q      <= 1'b0;
      av_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      match_q   <= match_d;
      rw_q      <= rw_d;
      gc_q      <= gc_d;
      av_q      <= av_d;
      busy_q    <= busy_d;
    end
  end

  assign scl_rise      = rise_w;
  assign scl_fall      = scl_prev & ~scl_cur;
  assign start_found   = start_w;
  assign rstart_found  = start_w & busy_q;
  assign stop_found    = stop_w;
  assign bus_busy      = busy_q;
  assign addr_valid    = av_q;
  assign address_match = match_q;
  assign rw_mode       = rw_q;
  assign general_call  = gc_q;

endmodule

// File: tb/tb_i2c_bus_decoder.sv
// Bench for i2c_bus_decoder: bus stimulus tasks,
// address results checked against a queue of expectations.
module tb_i2c_bus_decoder;

  localparam int P = 10;

  typedef struct packed {
    logic m;
    logic rw;
    logic gc;
  } exp_t;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_in = 1'b1;
  logic [6:0] slave_addr = 7'h78;
  logic [6:0] addr_mask = 7'h7F;

  logic scl_rise, scl_fall, start_found, rstart_found, stop_found;
  logic bus_busy, addr_valid, address_match, rw_mode, general_call;

  logic n_scl_rise, n_scl_fall, n_start, n_rstart, n_stop;
  logic n_busy, n_av, n_match, n_rw, n_gc;

  int checks = 0;
  int errors = 0;
  int st_cnt = 0;
  int rs_cnt = 0;
  int sp_cnt = 0;
  int rise_cnt = 0;
  logic av_prev = 1'b0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  i2c_bus_decoder u_dut (
    .clk(clk), .n_rst(n_rst), .scl(scl), .sda_in(sda_in),
    .slave_addr(slave_addr), .addr_mask(addr_mask),
    .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_found(start_found), .rstart_found(rstart_found),
    .stop_found(stop_found), .bus_busy(bus_busy),
    .addr_valid(addr_valid), .address_match(address_match),
    .rw_mode(rw_mode), .general_call(general_call)
  );

  i2c_bus_decoder #(.GC_EN(1'b0)) u_ngc (
    .clk(clk), .n_rst(n_rst), .scl(scl), .sda_in(sda_in),
    .slave_addr(slave_addr), .addr_mask(addr_mask),
    .scl_rise(n_scl_rise), .scl_fall(n_scl_fall),
    .start_found(n_start), .rstart_found(n_rstart),
    .stop_found(n_stop), .bus_busy(n_busy),
    .addr_valid(n_av), .address_match(n_match),
    .rw_mode(n_rw), .general_call(n_gc)
  );

  function automatic exp_t model(input logic [7:0] b);
    exp_t e;
    e.m  = (((b[7:1] ^ slave_addr) & addr_mask) == 7'd0);
    e.rw = b[0];
    e.gc = (b == 8'h00);
    return e;
  endfunction

  // Event counters and scoreboard pop on every captured address
  always @(negedge clk) begin
    if (start_found) st_cnt++;
    if (start_found && rstart_found) rs_cnt++;
    if (stop_found) sp_cnt++;
    if (scl_rise) rise_cnt++;
    if (addr_valid) begin
      checks++;
      if (av_prev) begin
        errors++;
        $display("FAIL av_width addr_valid high 2 cycles, want 1");
      end
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL av_unexpected addr_valid with no byte sent");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (address_match !== e.m) begin
          errors++;
          $display("FAIL match got %b want %b", address_match, e.m);
        end
        if (rw_mode !== e.rw) begin
          errors++;
          $display("FAIL rw got %b want %b", rw_mode, e.rw);
        end
        if (general_call !== e.gc) begin
          errors++;
          $display("FAIL gc got %b want %b", general_call, e.gc);
        end
        if (n_gc !== 1'b0 || n_av !== 1'b1) begin
          errors++;
          $display("FAIL gc_dis got gc=%b av=%b want 0 1", n_gc, n_av);
        end
        checks += 3;
      end
    end
    av_prev = addr_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cond();
    sda_in = 1'b0;
    tick(P);
    scl = 1'b0;
    tick(P);
  endtask

  task automatic send_bits(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      sda_in = b[i];
      tick(P);
      scl = 1'b1;
      tick(P);
      scl = 1'b0;
    end
    tick(P);
  endtask

  task automatic stop_cond();
    sda_in = 1'b0;
    tick(P);
    scl = 1'b1;
    tick(P);
    sda_in = 1'b1;
    tick(P);
  endtask

  task automatic test_reset();
    checks++;
    if ({scl_rise, scl_fall, start_found, rstart_found, stop_found,
         bus_busy, addr_valid, address_match, rw_mode,
         general_call} !== 10'd0) begin
      errors++;
      $display("FAIL reset_outs got %b want 0", {scl_rise, scl_fall,
        start_found, rstart_found, stop_found, bus_busy, addr_valid,
        address_match, rw_mode, general_call});
    end
    n_rst = 1'b1;
    tick(P);
    checks++;
    if (st_cnt != 0 || bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got st=%0d busy=%b want 0 0",
               st_cnt, bus_busy);
    end
  endtask

  task automatic test_addr_match();
    int lat = 0;
    int s0 = sp_cnt;
    slave_addr = 7'h78;
    addr_mask  = 7'h7F;
    sda_in = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      #1;
      if (start_found && lat == 0) lat = k;
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL start_lat got %0d want 4", lat);
    end
    tick(P);
    scl = 1'b0;
    tick(P);
    exp_q.push_back(model(8'hF1));
    send_bits(8'hF1, 7, 0);
    checks++;
    if (exp_q.size() != 0 || address_match !== 1'b1 ||
        rw_mode !== 1'b1 || bus_busy !== 1'b1) begin
      errors++;
      $display("FAIL f1_hold got q=%0d m=%b rw=%b busy=%b want 0 1 1 1",
               exp_q.size(), address_match, rw_mode, bus_busy);
    end
    stop_cond();
    checks++;
    if (sp_cnt != s0 + 1 || bus_busy !== 1'b0 || address_match !== 1'b0
        || rw_mode !== 1'b0) begin
      errors++;
      $display("FAIL stop1 got sp=%0d busy=%b m=%b rw=%b want %0d 0 0 0",
               sp_cnt - s0, bus_busy, address_match, rw_mode, 1);
    end
  endtask

  task automatic test_masked();
    slave_addr = 7'h79;
    addr_mask  = 7'h7E;
    start_cond();
    exp_q.push_back('{m: 1'b1, rw: 1'b0, gc: 1'b0});
    send_bits(8'hF0, 7, 0);
    stop_cond();
    start_cond();
    exp_q.push_back('{m: 1'b0, rw: 1'b0, gc: 1'b0});
    send_bits(8'h10, 7, 0);
    stop_cond();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL masked_pending got %0d want 0", exp_q.size());
    end
  endtask

  task automatic test_general_call();
    slave_addr = 7'h78;
    addr_mask  = 7'h7F;
    start_cond();
    exp_q.push_back('{m: 1'b0, rw: 1'b0, gc: 1'b1});
    send_bits(8'h00, 7, 0);
    checks++;
    if (exp_q.size() != 0 || general_call !== 1'b1 || n_gc !== 1'b0) begin
      errors++;
      $display("FAIL gc_hold got q=%0d gc=%b ngc=%b want 0 1 0",
               exp_q.size(), general_call, n_gc);
    end
    stop_cond();
  endtask

  task automatic test_rstart();
    int s0 = st_cnt;
    int r0 = rs_cnt;
    int p0 = sp_cnt;
    start_cond();
    exp_q.push_back(model(8'hF1));
    send_bits(8'hF1, 7, 0);
    sda_in = 1'b1;
    tick(P);
    scl = 1'b1;
    tick(P);
    sda_in = 1'b0;
    tick(P);
    checks++;
    if (st_cnt != s0 + 2 || rs_cnt != r0 + 1) begin
      errors++;
      $display("FAIL rstart got st=%0d rs=%0d want 2 1",
               st_cnt - s0, rs_cnt - r0);
    end
    checks++;
    if (address_match !== 1'b0 || rw_mode !== 1'b0 ||
        general_call !== 1'b0 || bus_busy !== 1'b1) begin
      errors++;
      $display("FAIL rstart_clr got m=%b rw=%b gc=%b busy=%b want 0 0 0 1",
               address_match, rw_mode, general_call, bus_busy);
    end
    scl = 1'b0;
    tick(P);
    exp_q.push_back(model(8'h00));
    send_bits(8'h00, 7, 0);
    stop_cond();
    checks++;
    if (sp_cnt != p0 + 1 || bus_busy !== 1'b0 || exp_q.size() != 0 ||
        general_call !== 1'b0) begin
      errors++;
      $display("FAIL rstart_stop got sp=%0d busy=%b q=%0d gc=%b want 1 0 0 0",
               sp_cnt - p0, bus_busy, exp_q.size(), general_call);
    end
  endtask

  task automatic test_glitch();
    int s0 = st_cnt;
    int r0;
    sda_in = 1'b0;
    tick(1);
    sda_in = 1'b1;
    tick(P);
    checks++;
    if (st_cnt != s0 || bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL sda_glitch got st=%0d busy=%b want 0 0",
               st_cnt - s0, bus_busy);
    end
    start_cond();
    r0 = rise_cnt;
    exp_q.push_back(model(8'hF1));
    send_bits(8'hF1, 7, 4);
    tick(3);
    scl = 1'b1;
    tick(1);
    scl = 1'b0;
    tick(P);
    send_bits(8'hF1, 3, 0);
    checks++;
    if (rise_cnt != r0 + 8 || exp_q.size() != 0 ||
        address_match !== 1'b1) begin
      errors++;
      $display("FAIL scl_glitch got rises=%0d q=%0d m=%b want 8 0 1",
               rise_cnt - r0, exp_q.size(), address_match);
    end
    stop_cond();
  endtask

  task automatic test_reset_mid();
    int s0;
    start_cond();
    send_bits(8'hA5, 7, 4);
    checks++;
    if (bus_busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b want 1", bus_busy);
    end
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({bus_busy, addr_valid, address_match, rw_mode, general_call,
         start_found, stop_found, scl_rise, scl_fall} !== 9'd0) begin
      errors++;
      $display("FAIL async_rst got %b want 0", {bus_busy, addr_valid,
        address_match, rw_mode, general_call, start_found, stop_found,
        scl_rise, scl_fall});
    end
    scl = 1'b1;
    sda_in = 1'b1;
    tick(3);
    s0 = st_cnt;
    n_rst = 1'b1;
    tick(P);
    checks++;
    if (st_cnt != s0 || bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL post_rst got st=%0d busy=%b want 0 0",
               st_cnt - s0, bus_busy);
    end
    start_cond();
    exp_q.push_back('{m: 1'b1, rw: 1'b0, gc: 1'b0});
    send_bits(8'hF0, 7, 0);
    checks++;
    if (exp_q.size() != 0 || address_match !== 1'b1 || rw_mode !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_cap got q=%0d m=%b rw=%b want 0 1 0",
               exp_q.size(), address_match, rw_mode);
    end
    stop_cond();
  endtask

  initial begin
    tick(3);
    test_reset();
    test_addr_match();
    test_masked();
    test_general_call();
    test_rstart();
    test_glitch();
    test_reset_mid();
    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
